// File: rtl/tx_serial_uart.sv
// tx_serial_uart: asynchronous serial transmitter for uc_envia_dados.
// Frame: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// A one-entry holding register queues the next byte while the current one is on the line.
// Optional parity bit enabled by defining TX_PARIDADE_EN.
module tx_serial_uart #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       buffer_cheio,
    output logic       pronto,
    output logic       erro_overrun,
    output logic [3:0] db_estado
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [3:0] {
        ST_INICIAL    = 4'd0,
        ST_ESPERA     = 4'd1,
        ST_START_BIT  = 4'd2,
        ST_DADOS_BITS = 4'd3,
        ST_PARIDADE   = 4'd4,
        ST_STOP_BITS  = 4'd5,
        ST_FINAL      = 4'd6,
        ST_ERRO       = 4'd15
    } estado_t;

    estado_t          state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       data_reg;
    logic [7:0]       hold_reg;
    logic             buffer_cheio_reg;
    logic             erro_overrun_reg;
    logic             baud_tick;

    assign baud_tick = (baud_cnt_reg == BAUD_LAST);

    // State register; reset parks the FSM in inicial with the line idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= ST_INICIAL;
        else        state_reg <= state_next;
    end

    // Next-state logic; stop bits are counted with the bit counter, one bit period each.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INICIAL:    state_next = ST_ESPERA;
            ST_ESPERA:     if (partida) state_next = ST_START_BIT;
            ST_START_BIT:  if (baud_tick) state_next = ST_DADOS_BITS;
            ST_DADOS_BITS: if (baud_tick && bit_cnt_reg == 3'd7) begin
`ifdef TX_PARIDADE_EN
                state_next = ST_PARIDADE;
`else
                state_next = ST_STOP_BITS;
`endif
            end
`ifdef TX_PARIDADE_EN
            ST_PARIDADE:   if (baud_tick) state_next = ST_STOP_BITS;
`endif
            ST_STOP_BITS:  if (baud_tick && bit_cnt_reg == STOP_LAST) state_next = ST_FINAL;
            // A byte captured on the final cycle itself is sent straight away.
            ST_FINAL:      state_next = (buffer_cheio_reg || partida) ? ST_START_BIT : ST_ESPERA;
            ST_ERRO:       state_next = ST_INICIAL;
            default:       state_next = ST_ERRO;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        saida_serial = 1'b1;
        ocupado      = 1'b0;
        pronto       = 1'b0;
        case (state_reg)
            ST_START_BIT: begin
                saida_serial = 1'b0;
                ocupado      = 1'b1;
            end
            ST_DADOS_BITS: begin
                saida_serial = data_reg[bit_cnt_reg];
                ocupado      = 1'b1;
            end
            ST_PARIDADE: begin
                saida_serial = ^data_reg;
                ocupado      = 1'b1;
            end
            ST_STOP_BITS: ocupado = 1'b1;
            ST_FINAL: begin
                ocupado = 1'b1;
                pronto  = 1'b1;
            end
            default: ;
        endcase
    end

    // Baud and bit counters; both restart whenever the state changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (state_next != state_reg) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (baud_tick) begin
            baud_cnt_reg <= '0;
            if (state_reg == ST_DADOS_BITS || state_reg == ST_STOP_BITS)
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
        end
    end

    // Byte capture: direct load when idle or in final, holding register while busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_reg         <= '0;
            hold_reg         <= '0;
            buffer_cheio_reg <= 1'b0;
            erro_overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ESPERA: if (partida) data_reg <= dados;
                ST_FINAL: begin
                    if (buffer_cheio_reg) begin
                        data_reg         <= hold_reg;
                        buffer_cheio_reg <= 1'b0;
                        if (partida) erro_overrun_reg <= 1'b1;
                    end else if (partida) begin
                        data_reg <= dados;
                    end
                end
                ST_START_BIT, ST_DADOS_BITS, ST_PARIDADE, ST_STOP_BITS: begin
                    if (partida) begin
                        if (buffer_cheio_reg) begin
                            erro_overrun_reg <= 1'b1;
                        end else begin
                            hold_reg         <= dados;
                            buffer_cheio_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign buffer_cheio = buffer_cheio_reg;
    assign erro_overrun = erro_overrun_reg;
    assign db_estado    = state_reg;

endmodule

// File: tb/tb_tx_serial_uart.sv
// Directed bench for tx_serial_uart with DIV=4, STOP_BITS=2.
module tb_tx_serial_uart;

    logic       clock = 1'b0;
    logic       reset;
    logic       partida;
    logic [7:0] dados;
    logic       saida_serial, ocupado, buffer_cheio, pronto, erro_overrun;
    logic [3:0] db_estado;

    int n_vec = 0;
    int n_err = 0;

`ifdef TX_PARIDADE_EN
    localparam int P = 49;
`else
    localparam int P = 45;
`endif

    tx_serial_uart #(.CLK_HZ(400), .BAUD(100), .STOP_BITS(2)) dut (
        .clock(clock), .reset(reset), .partida(partida), .dados(dados),
        .saida_serial(saida_serial), .ocupado(ocupado), .buffer_cheio(buffer_cheio),
        .pronto(pronto), .erro_overrun(erro_overrun), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level c cycles after the accepting edge (c=1 is the first start-bit cycle).
    function automatic logic exp_line(input logic [7:0] b, input int c);
        if (c <= 4) return 1'b0;
        if (c <= 36) return b[(c - 5) / 4];
`ifdef TX_PARIDADE_EN
        if (c <= 40) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_db"}, {4'd0, db_estado}, 8'd1);
        check({tag, "_ocupado"}, {7'd0, ocupado}, 8'd0);
        check({tag, "_line"}, {7'd0, saida_serial}, 8'd1);
    endtask

    initial begin
        reset   = 1'b0;
        partida = 1'b0;
        dados   = 8'h00;

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_line", {7'd0, saida_serial}, 8'd1);
            check("rst_ocupado", {7'd0, ocupado}, 8'd0);
            check("rst_pronto", {7'd0, pronto}, 8'd0);
            check("rst_db", {4'd0, db_estado}, 8'd0);
            check("rst_buf", {7'd0, buffer_cheio}, 8'd0);
            check("rst_ovr", {7'd0, erro_overrun}, 8'd0);
        end
        reset = 1'b1;
        step();
        check_idle("post_rst");

        // Single byte A5
        partida = 1'b1; dados = 8'hA5;
        step();
        partida = 1'b0;
        for (int c = 1; c <= P; c++) begin
            check($sformatf("a5_line_c%0d", c), {7'd0, saida_serial}, {7'd0, exp_line(8'hA5, c)});
            check($sformatf("a5_pronto_c%0d", c), {7'd0, pronto}, {7'd0, c == P});
            check($sformatf("a5_ocupado_c%0d", c), {7'd0, ocupado}, 8'd1);
            if (c < P) step();
        end
        check("a5_final_db", {4'd0, db_estado}, 8'd6);
        step();
        check_idle("a5_end");
        check("a5_end_pronto", {7'd0, pronto}, 8'd0);

        // Back-to-back 01 then FF, second request at N+10
        partida = 1'b1; dados = 8'h01;
        step();
        partida = 1'b0;
        for (int c = 1; c <= 2 * P; c++) begin
            if (c == 10) begin partida = 1'b1; dados = 8'hFF; end
            if (c == 11) partida = 1'b0;
            check($sformatf("b2b_line_c%0d", c), {7'd0, saida_serial},
                  {7'd0, (c <= P) ? exp_line(8'h01, c) : exp_line(8'hFF, c - P)});
            check($sformatf("b2b_pronto_c%0d", c), {7'd0, pronto}, {7'd0, (c == P) || (c == 2 * P)});
            check($sformatf("b2b_ocupado_c%0d", c), {7'd0, ocupado}, 8'd1);
            check($sformatf("b2b_buf_c%0d", c), {7'd0, buffer_cheio}, {7'd0, (c >= 11) && (c <= P)});
            if (c == P + 1) check("b2b_second_start_db", {4'd0, db_estado}, 8'd2);
            if (c < 2 * P) step();
        end
        step();
        check_idle("b2b_end");
        check("b2b_no_ovr", {7'd0, erro_overrun}, 8'd0);

        // Overrun: three requests on consecutive edges
        partida = 1'b1; dados = 8'h10;
        step();
        dados = 8'h20;
        for (int c = 1; c <= 2 * P; c++) begin
            if (c == 2) dados = 8'h30;
            if (c == 3) partida = 1'b0;
            check($sformatf("ovr_line_c%0d", c), {7'd0, saida_serial},
                  {7'd0, (c <= P) ? exp_line(8'h10, c) : exp_line(8'h20, c - P)});
            check($sformatf("ovr_flag_c%0d", c), {7'd0, erro_overrun}, {7'd0, c >= 3});
            if (c < 2 * P) step();
        end
        step();
        check_idle("ovr_end");
        check("ovr_sticky", {7'd0, erro_overrun}, 8'd1);

        // Reset mid-frame during data bits
        partida = 1'b1; dados = 8'hC3;
        step();
        partida = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check("mid_db_before", {4'd0, db_estado}, 8'd3);
        #3 reset = 1'b0;
        #1;
        check("mid_line_async", {7'd0, saida_serial}, 8'd1);
        check("mid_db_async", {4'd0, db_estado}, 8'd0);
        check("mid_ovr_clr", {7'd0, erro_overrun}, 8'd0);
        check("mid_ocupado", {7'd0, ocupado}, 8'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mid_hold_pronto", {7'd0, pronto}, 8'd0);
            check("mid_hold_line", {7'd0, saida_serial}, 8'd1);
        end
        reset = 1'b1;
        step();
        check_idle("mid_release");
        partida = 1'b1; dados = 8'h3C;
        step();
        partida = 1'b0;
        for (int c = 1; c <= P; c++) begin
            check($sformatf("3c_line_c%0d", c), {7'd0, saida_serial}, {7'd0, exp_line(8'h3C, c)});
            check($sformatf("3c_pronto_c%0d", c), {7'd0, pronto}, {7'd0, c == P});
            if (c < P) step();
        end
        step();
        check_idle("3c_end");

`ifdef TX_PARIDADE_EN
        // Parity frame for 07
        partida = 1'b1; dados = 8'h07;
        step();
        partida = 1'b0;
        for (int c = 1; c <= P; c++) begin
            check($sformatf("par_line_c%0d", c), {7'd0, saida_serial}, {7'd0, exp_line(8'h07, c)});
            check($sformatf("par_pronto_c%0d", c), {7'd0, pronto}, {7'd0, c == P});
            if (c >= 37 && c <= 40) check("par_state", {4'd0, db_estado}, 8'd4);
            if (c < P) step();
        end
        step();
        check_idle("par_end");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
